// File: rtl/usr_seq.sv
// usr_seq: command sequencer driving the universal shift register (usr).
// Accepts one command per valid/ready handshake (NOP, shift right N,
// shift left N with a fill bit, parallel load), steps usr through the
// required cycles, then captures usr_q as result and pulses done.
// Optional feature macro: USR_SEQ_ROTATE_EN adds cmd_rot, which replaces
// the fill bit with the bit falling off the opposite end of usr_q so that
// a shift becomes a rotate.
module usr_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
`ifdef USR_SEQ_ROTATE_EN
  input  logic             cmd_rot,
`endif
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] data_in,
  output logic             serial_in_left,
  output logic             serial_in_right,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             sil_q;
  logic             sir_q;
`ifdef USR_SEQ_ROTATE_EN
  logic             rot_q;
`endif

  // Handshake and status derive directly from the state register; ready is
  // forced low while reset is held so nothing can be accepted during reset.
  assign cmd_ready = (state == S_IDLE) && rst;
  assign busy      = (state != S_IDLE);

`ifdef USR_SEQ_ROTATE_EN
  // In a rotate, the serial input is fed straight from the bit that usr is
  // about to shift out, so it must follow usr_q in the same cycle.
  always_comb begin
    serial_in_left  = sil_q;
    serial_in_right = sir_q;
    if (rot_q && (state == S_SHIFT)) begin
      if (mode == MODE_RIGHT) begin
        serial_in_left = usr_q[0];
      end
      if (mode == MODE_LEFT) begin
        serial_in_right = usr_q[WIDTH-1];
      end
    end
  end
`else
  assign serial_in_left  = sil_q;
  assign serial_in_right = sir_q;
`endif

  // Main sequencer: latches a command, registers the usr controls for the
  // active cycles, and captures the result one cycle after the last update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      mode      <= MODE_HOLD;
      data_in   <= '0;
      sil_q     <= 1'b0;
      sir_q     <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
`ifdef USR_SEQ_ROTATE_EN
      rot_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            remaining <= cmd_count;
`ifdef USR_SEQ_ROTATE_EN
            rot_q     <= cmd_rot;
`endif
            case (cmd_op)
              MODE_LOAD: begin
                data_in <= cmd_data;
                mode    <= MODE_LOAD;
                state   <= S_LOAD;
              end
              MODE_RIGHT, MODE_LEFT: begin
                if (cmd_count != '0) begin
                  mode  <= cmd_op;
                  sil_q <= (cmd_op == MODE_RIGHT) ? cmd_fill : 1'b0;
                  sir_q <= (cmd_op == MODE_LEFT)  ? cmd_fill : 1'b0;
                  state <= S_SHIFT;
                end else begin
                  state <= S_DONE;
                end
              end
              default: begin
                state <= S_DONE;
              end
            endcase
          end
        end
        S_LOAD: begin
          mode  <= MODE_HOLD;
          state <= S_DONE;
        end
        S_SHIFT: begin
          if (remaining == CNT_W'(1)) begin
            mode  <= MODE_HOLD;
            sil_q <= 1'b0;
            sir_q <= 1'b0;
            state <= S_DONE;
          end else begin
            remaining <= remaining - CNT_W'(1);
          end
        end
        S_DONE: begin
          result <= usr_q;
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usr_seq.sv
// tb_usr_seq: directed self-checking bench for usr_seq with a small
// behavioural usr model closing the loop on usr_q.
module tb_usr_seq;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_count;
  logic       cmd_fill;
`ifdef USR_SEQ_ROTATE_EN
  logic       cmd_rot;
`endif
  logic [3:0] usr_q;
  logic [1:0] mode;
  logic [3:0] data_in;
  logic       serial_in_left;
  logic       serial_in_right;
  logic       busy;
  logic       done;
  logic [3:0] result;

  int checks = 0;
  int errors = 0;

  usr_seq #(.WIDTH(4), .CNT_W(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_data        (cmd_data),
    .cmd_count       (cmd_count),
    .cmd_fill        (cmd_fill),
`ifdef USR_SEQ_ROTATE_EN
    .cmd_rot         (cmd_rot),
`endif
    .usr_q           (usr_q),
    .mode            (mode),
    .data_in         (data_in),
    .serial_in_left  (serial_in_left),
    .serial_in_right (serial_in_right),
    .busy            (busy),
    .done            (done),
    .result          (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural universal shift register fed by the sequencer outputs.
  initial usr_q = 4'b0000;
  always @(posedge clk) begin
    case (mode)
      2'b01:   usr_q <= {serial_in_left, usr_q[3:1]};
      2'b10:   usr_q <= {usr_q[2:0], serial_in_right};
      2'b11:   usr_q <= data_in;
      default: usr_q <= usr_q;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a command for exactly one edge, then scrambles cmd_* to prove
  // the sequencer latched its copy.
  task automatic apply_stimulus(input logic [1:0] op, input logic [3:0] data,
                                input logic [2:0] count, input logic fill, input logic rot);
    check_output("ready_before_accept", 8'(cmd_ready), 8'd1);
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = count;
    cmd_fill  = fill;
`ifdef USR_SEQ_ROTATE_EN
    cmd_rot   = rot;
`else
    if (rot) $display("[TB] rotate requested without rotate build");
`endif
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = ~data;
    cmd_count = ~count;
    cmd_fill  = ~fill;
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] data,
                         input logic [2:0] count, input logic fill, input logic rot,
                         input logic [1:0] exp_mode, input logic exp_sil, input logic exp_sir,
                         input int active, input logic [3:0] exp_result);
    $display("[TB] command %s", tag);
    apply_stimulus(op, data, count, fill, rot);
    check_output({tag, "_mode"}, 8'(mode), 8'(exp_mode));
    check_output({tag, "_busy"}, 8'(busy), 8'd1);
    check_output({tag, "_ready_low"}, 8'(cmd_ready), 8'd0);
    check_output({tag, "_sil"}, 8'(serial_in_left), 8'(exp_sil));
    check_output({tag, "_sir"}, 8'(serial_in_right), 8'(exp_sir));
    if (op == 2'b11) check_output({tag, "_data_in"}, 8'(data_in), 8'(data));
    repeat (active) begin
      tick();
      check_output({tag, "_no_early_done"}, 8'(done), 8'd0);
    end
    tick();
    check_output({tag, "_done"}, 8'(done), 8'd1);
    check_output({tag, "_result"}, 8'(result), 8'(exp_result));
    check_output({tag, "_ready_back"}, 8'(cmd_ready), 8'd1);
    check_output({tag, "_idle_mode"}, 8'(mode), 8'd0);
    tick();
    check_output({tag, "_done_pulse"}, 8'(done), 8'd0);
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'b0000;
    cmd_count = 3'd0;
    cmd_fill  = 1'b0;
`ifdef USR_SEQ_ROTATE_EN
    cmd_rot   = 1'b0;
`endif
    #2;
    check_output("rst_ready", 8'(cmd_ready), 8'd0);
    check_output("rst_mode", 8'(mode), 8'd0);
    check_output("rst_data_in", 8'(data_in), 8'd0);
    check_output("rst_busy", 8'(busy), 8'd0);
    check_output("rst_done", 8'(done), 8'd0);
    check_output("rst_result", 8'(result), 8'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_output("post_rst_ready", 8'(cmd_ready), 8'd1);
    tick();

    run_cmd("load_1010", 2'b11, 4'b1010, 3'd0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1, 4'b1010);
    run_cmd("shr1_fill1", 2'b01, 4'b0000, 3'd1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1, 4'b1101);
    run_cmd("shl3_fill0", 2'b10, 4'b0000, 3'd3, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 3, 4'b1000);
    run_cmd("shr_count0", 2'b01, 4'b0000, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 0, 4'b1000);
    run_cmd("nop", 2'b00, 4'b1111, 3'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 0, 4'b1000);
    check_output("data_in_kept", 8'(data_in), 8'b1010);

    // Hold-off: second command held valid through a 7-cycle shift.
    $display("[TB] command hold_off");
    cmd_op    = 2'b01;
    cmd_count = 3'd7;
    cmd_fill  = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_op   = 2'b11;
    cmd_data = 4'b0101;
    check_output("hold_ready_k", 8'(cmd_ready), 8'd0);
    check_output("hold_mode_k", 8'(mode), 8'b01);
    repeat (6) begin
      tick();
      check_output("hold_ready", 8'(cmd_ready), 8'd0);
      check_output("hold_busy", 8'(busy), 8'd1);
      check_output("hold_mode", 8'(mode), 8'b01);
    end
    tick();
    check_output("hold_last_ready", 8'(cmd_ready), 8'd0);
    check_output("hold_last_mode", 8'(mode), 8'd0);
    check_output("hold_last_done", 8'(done), 8'd0);
    tick();
    check_output("hold_done", 8'(done), 8'd1);
    check_output("hold_result", 8'(result), 8'b0000);
    check_output("hold_ready_in_done", 8'(cmd_ready), 8'd1);
    tick();
    cmd_valid = 1'b0;
    check_output("second_mode", 8'(mode), 8'b11);
    check_output("second_data_in", 8'(data_in), 8'b0101);
    check_output("second_no_done", 8'(done), 8'd0);
    tick();
    check_output("second_hold_mode", 8'(mode), 8'd0);
    tick();
    check_output("second_done", 8'(done), 8'd1);
    check_output("second_result", 8'(result), 8'b0101);
    tick();

    // Reset in the middle of a left shift of 0101 with fill 1.
    $display("[TB] command reset_mid_shift");
    apply_stimulus(2'b10, 4'b0000, 3'd5, 1'b1, 1'b0);
    tick();
    tick();
    check_output("mid_q", 8'(usr_q), 8'b0111);
    rst = 1'b0;
    #1;
    check_output("mid_rst_mode", 8'(mode), 8'd0);
    check_output("mid_rst_sir", 8'(serial_in_right), 8'd0);
    check_output("mid_rst_sil", 8'(serial_in_left), 8'd0);
    check_output("mid_rst_data_in", 8'(data_in), 8'd0);
    check_output("mid_rst_busy", 8'(busy), 8'd0);
    check_output("mid_rst_ready", 8'(cmd_ready), 8'd0);
    check_output("mid_rst_result", 8'(result), 8'd0);
    tick();
    tick();
    check_output("mid_rst_q_held", 8'(usr_q), 8'b0111);
    check_output("mid_rst_no_done", 8'(done), 8'd0);
    rst = 1'b1;
    #1;
    check_output("mid_rel_ready", 8'(cmd_ready), 8'd1);
    tick();
    check_output("mid_rel_no_done", 8'(done), 8'd0);
    run_cmd("load_0110", 2'b11, 4'b0110, 3'd0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1, 4'b0110);

`ifdef USR_SEQ_ROTATE_EN
    run_cmd("load_1001", 2'b11, 4'b1001, 3'd0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1, 4'b1001);
    run_cmd("rotr1", 2'b01, 4'b0000, 3'd1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1, 4'b1100);
    run_cmd("rotl2", 2'b10, 4'b0000, 3'd2, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2, 4'b0011);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usr_seq.md
# usr_seq

Command sequencer that sits directly upstream of the universal shift register (`usr`) and drives its `mode`, `data_in`, `serial_in_left` and `serial_in_right` inputs. It accepts one command at a time over a valid/ready handshake: parallel load, shift right N, or shift left N with a fill bit. It runs the required number of register cycles, then captures the register's `q` as `result` and pulses `done`.

## Interface
- `WIDTH`, 4: shift register width; must match `usr`.
- `CNT_W`, 3: width of the shift count; maximum shift per command is 2^CNT_W-1.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_op` in 2: 00 NOP, 01 shift right, 10 shift left, 11 load.
- `cmd_data` in WIDTH: parallel load value, used for op 11 only.
- `cmd_count` in CNT_W: number of shift cycles, used for ops 01/10 only.
- `cmd_fill` in 1: bit shifted in on every shift cycle.
- `usr_q` in WIDTH: `q` fed back from `usr`.
- `mode` out 2: to `usr`; 00 hold, 01 shift right, 10 shift left, 11 load.
- `data_in` out WIDTH: to `usr`.
- `serial_in_left` out 1: to `usr`; enters the MSB on a right shift.
- `serial_in_right` out 1: to `usr`; enters the LSB on a left shift.
- `busy` out 1: a command is in progress.
- `done` out 1: one-cycle completion pulse.
- `result` out WIDTH: `usr_q` captured at completion.

## Operation
- `usr` semantics the sequencer relies on:
  - Right shift: q <= {serial_in_left, q[WIDTH-1:1]}.
  - Left shift: q <= {q[WIDTH-2:0], serial_in_right}.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - `cmd_ready`=1 and `mode`=00.
  - Accept on `cmd_valid && cmd_ready`, latching op, data, count and fill.
  - Next state: op 11 -> LOAD; op 01/10 with count>0 -> SHIFT; NOP or count 0 -> DONE.
- LOAD: one cycle. `mode`=11, `data_in`=latched data. Next state DONE.
- SHIFT:
  - `mode`=01 or 10, with the fill bit on `serial_in_left` (right shift) or `serial_in_right` (left shift).
  - The unused serial input is driven 0.
  - Remaining count decrements each cycle; leave for DONE after the cycle in which remaining=1.
- DONE: one cycle. `mode`=00. On exit, `result`<=`usr_q`, `done`<=1 for one cycle, state -> IDLE.
- `busy`=1 in LOAD, SHIFT and DONE.
- `cmd_ready` = (state==IDLE) and `rst` deasserted.
- Commands presented while busy are held off, not dropped. `cmd_*` may change freely after acceptance.
- `mode` and `data_in` are registered. `data_in` keeps its last loaded value outside LOAD.
- Reset, asynchronous, at any point including mid-command:
  - State -> IDLE; the command in progress is abandoned.
  - `mode`=00, `data_in`=0, both serial outputs 0.
  - `busy`=0, `done`=0, `result`=0, `cmd_ready`=0 while `rst` is low.

## Timing
- Command accepted at edge k; active cycles A: load=1, shift=count, NOP/count0=0.
- `usr` acts on edges k+1 .. k+A.
- `result` is valid and `done`=1 during the cycle after edge k+A+1.
- `cmd_ready` rises in that same cycle, so back-to-back commands run with no gap.
- Throughput: one command per A+2 cycles.
- `usr_q` is sampled only in DONE, one full cycle after the last `usr` update.

## Configuration
- Macro: `USR_SEQ_ROTATE_EN`.
- Defined:
  - Adds input port `cmd_rot` (1 bit), latched at accept.
  - When set, the fill on each shift cycle is combinational from `usr_q`: `usr_q[0]` for a right shift, `usr_q[WIDTH-1]` for a left shift, giving a rotate. `cmd_fill` is then ignored.
- Undefined: `cmd_rot` port absent; the fill is always the latched `cmd_fill`; all serial outputs are registered.

## Test plan
- Reset, then load `cmd_data`=1010 at edge k -> `mode`=11 for one cycle; `done`=1 and `result`=1010 after edge k+2.
- From 1010: shift right, count 1, fill 1 -> `result`=1101, `done` after edge k+2. Then shift left, count 3, fill 0 -> `result`=1000, `done` after edge k+4.
- Shift with count 0 from 1000, and a NOP -> `mode` stays 00; `result`=1000, `done` after edge k+1.
- Hold `cmd_valid` high during a 7-cycle shift -> second command accepted only in the `done` cycle; `cmd_ready`=0 throughout `busy`.
- Drive `rst` low in the middle of SHIFT -> all outputs are reset values immediately, `usr` holds, no `done`. After release, a fresh load of 0110 completes normally.
- With `USR_SEQ_ROTATE_EN`: load 1001, rotate right 1 -> `result`=1100; rotate left 2 from 1100 -> `result`=0011.
